// File: rtl/bus_arbiter.sv
// Round-robin arbiter for three processors sharing one registered bus, with a memory-wait state.
// Define ARB_TIMEOUT_EN to add an ownership watchdog limited to TIMEOUT cycles.
module bus_arbiter #(
  parameter int unsigned MSG_W   = 9,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       req,
  input  logic [MSG_W-1:0] msg1,
  input  logic [MSG_W-1:0] msg2,
  input  logic [MSG_W-1:0] msg3,
  input  logic             mem_req,
  input  logic             mem_valid,
  input  logic [MSG_W-1:0] mem_data,
  output logic [2:0]       grant,
  output logic [MSG_W-1:0] busOut,
  output logic             busValid,
  output logic             timeout
);

  typedef enum logic [1:0] {StIdle, StOwn, StMemWait} state_e;

  state_e           state_q;
  logic [1:0]       last_winner_q;
  logic [1:0]       winner;
  logic [2:0]       winner_oh;
  logic             owner_req;
  logic [MSG_W-1:0] owner_msg;
  logic             wd_expired;

  // Search starts at the index after the previous winner, wrapping 2 -> 0.
  always_comb begin
    winner = 2'd0;
    unique case (last_winner_q)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  assign winner_oh = 3'(3'b001 << winner);
  assign owner_req = |(req & grant);

  always_comb begin
    owner_msg = '0;
    unique case (grant)
      3'b001:  owner_msg = msg1;
      3'b010:  owner_msg = msg2;
      3'b100:  owner_msg = msg3;
      default: owner_msg = '0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wd_cnt_q;

  assign wd_expired = (state_q != StIdle) && (wd_cnt_q == CntW'(TIMEOUT));

  // Counts every owned cycle; any path back to idle clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
    end else if (state_q != StIdle && !wd_expired && owner_req) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end else begin
      wd_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      grant         <= '0;
      busOut        <= '0;
      busValid      <= 1'b0;
      timeout       <= 1'b0;
      last_winner_q <= 2'd2;
    end else begin
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busOut   <= '0;
          busValid <= 1'b0;
          if (|req) begin
            grant         <= winner_oh;
            last_winner_q <= winner;
            state_q       <= StOwn;
          end else begin
            grant <= '0;
          end
        end
        StOwn, StMemWait: begin
          if (wd_expired) begin
            // Forced-out owner stays as last_winner, so the others go first.
            timeout  <= 1'b1;
            grant    <= '0;
            busOut   <= '0;
            busValid <= 1'b0;
            state_q  <= StIdle;
          end else if (!owner_req) begin
            grant    <= '0;
            busOut   <= '0;
            busValid <= 1'b0;
            state_q  <= StIdle;
          end else if (state_q == StOwn) begin
            if (mem_req) begin
              busOut   <= '0;
              busValid <= 1'b0;
              state_q  <= StMemWait;
            end else begin
              busOut   <= owner_msg;
              busValid <= 1'b1;
            end
          end else if (mem_valid) begin
            busOut   <= mem_data;
            busValid <= 1'b1;
            state_q  <= StOwn;
          end else begin
            busOut   <= '0;
            busValid <= 1'b0;
          end
        end
        default: begin
          grant    <= '0;
          busOut   <= '0;
          busValid <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: the driver queues per-cycle expectations, a monitor checks them.
// The watchdog scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  localparam logic [8:0] M1 = 9'h111;
  localparam logic [8:0] M2 = 9'h0A5;
  localparam logic [8:0] M3 = 9'h033;
  localparam logic [8:0] MD = 9'h1C3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] req;
  logic [8:0] msg1, msg2, msg3;
  logic       mem_req, mem_valid;
  logic [8:0] mem_data;
  logic [2:0] grant;
  logic [8:0] busOut;
  logic       busValid;
  logic       timeout;

  typedef struct {
    logic [2:0] g;
    logic [8:0] b;
    logic       v;
    logic       t;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n_step = 0;

  bus_arbiter #(.MSG_W(9), .TIMEOUT(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .msg1      (msg1),
    .msg2      (msg2),
    .msg3      (msg3),
    .mem_req   (mem_req),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .grant     (grant),
    .busOut    (busOut),
    .busValid  (busValid),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic step(input logic [2:0] r, input logic mr, input logic mv, input logic [8:0] md,
                      input logic [2:0] eg, input logic [8:0] eb, input logic ev, input logic et);
    exp_t e;
    @(negedge clock);
    req       = r;
    mem_req   = mr;
    mem_valid = mv;
    mem_data  = md;
    e.g  = eg;
    e.b  = eb;
    e.v  = ev;
    e.t  = et;
    e.id = n_step;
    n_step++;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [2:0] eg, input logic [8:0] eb, input logic ev,
                     input logic et);
    total++;
    if ({grant, busOut, busValid, timeout} !== {eg, eb, ev, et}) begin
      bad++;
      $display("FAIL %s: got grant=%b bus=%h valid=%b timeout=%b, want grant=%b bus=%h valid=%b timeout=%b",
               nm, grant, busOut, busValid, timeout, eg, eb, ev, et);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({grant, busOut, busValid, timeout} !== {e.g, e.b, e.v, e.t}) begin
          bad++;
          $display("FAIL s%0d: got grant=%b bus=%h valid=%b timeout=%b, want grant=%b bus=%h valid=%b timeout=%b",
                   e.id, grant, busOut, busValid, timeout, e.g, e.b, e.v, e.t);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    req       = 3'b000;
    mem_req   = 1'b0;
    mem_valid = 1'b0;
    mem_data  = '0;
    msg1      = M1;
    msg2      = M2;
    msg3      = M3;
    repeat (2) @(negedge clock);
    chk("reset", 3'b000, 9'h000, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Round-robin order after reset with everyone requesting.
    step(3'b111, 0, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b111, 0, 0, 9'h000, 3'b001, M1,     1, 0);
    step(3'b110, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);
    step(3'b110, 0, 0, 9'h000, 3'b010, 9'h000, 0, 0);
    step(3'b101, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);
    step(3'b101, 0, 0, 9'h000, 3'b100, 9'h000, 0, 0);
    step(3'b011, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);
    step(3'b011, 0, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b000, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);

    // P2 message on the bus, then release.
    step(3'b010, 0, 0, 9'h000, 3'b010, 9'h000, 0, 0);
    step(3'b010, 0, 0, 9'h000, 3'b010, M2,     1, 0);
    step(3'b000, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);

    // P1 memory read: four-cycle wait, data for one cycle, then msg1; mem_valid in OWN ignored.
    step(3'b001, 0, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b001, 0, 0, 9'h000, 3'b001, M1,     1, 0);
    step(3'b001, 1, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b001, 0, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b001, 0, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b001, 0, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b001, 0, 1, MD,     3'b001, MD,     1, 0);
    step(3'b001, 0, 0, 9'h000, 3'b001, M1,     1, 0);
    step(3'b001, 0, 1, 9'h0FF, 3'b001, M1,     1, 0);
    step(3'b000, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);

    // P3 drops req as mem_req rises: release wins, later mem_valid ignored in IDLE.
    step(3'b100, 0, 0, 9'h000, 3'b100, 9'h000, 0, 0);
    step(3'b100, 0, 0, 9'h000, 3'b100, M3,     1, 0);
    step(3'b000, 1, 0, 9'h000, 3'b000, 9'h000, 0, 0);
    step(3'b000, 0, 1, MD,     3'b000, 9'h000, 0, 0);
    step(3'b000, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);

    // No preemption by P2; owner abort from MEMWAIT, stale mem_valid ignored.
    step(3'b011, 0, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b011, 0, 0, 9'h000, 3'b001, M1,     1, 0);
    step(3'b011, 1, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    step(3'b010, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);
    step(3'b000, 0, 1, MD,     3'b000, 9'h000, 0, 0);

    // Asynchronous reset while P3 waits on memory.
    step(3'b100, 0, 0, 9'h000, 3'b100, 9'h000, 0, 0);
    step(3'b100, 1, 0, 9'h000, 3'b100, 9'h000, 0, 0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    req     = 3'b000;
    mem_req = 1'b0;
    #1;
    chk("async_reset", 3'b000, 9'h000, 1'b0, 1'b0);
    @(negedge clock);
    chk("reset_hold", 3'b000, 9'h000, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(3'b100, 0, 0, 9'h000, 3'b100, 9'h000, 0, 0);
    step(3'b100, 0, 0, 9'h000, 3'b100, M3,     1, 0);
    step(3'b000, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);

`ifdef ARB_TIMEOUT_EN
    // P1 hogs the bus with P2 waiting: 17 owned cycles, timeout pulse, then P2.
    step(3'b011, 0, 0, 9'h000, 3'b001, 9'h000, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(3'b011, 0, 0, 9'h000, 3'b001, M1, 1, 0);
    end
    step(3'b011, 0, 0, 9'h000, 3'b000, 9'h000, 0, 1);
    step(3'b011, 0, 0, 9'h000, 3'b010, 9'h000, 0, 0);
    step(3'b000, 0, 0, 9'h000, 3'b000, 9'h000, 0, 0);
`endif

    repeat (3) @(negedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
